press_counter_7seg: RTL

PRESS_COUNTER_7SEG -- requirements
Module: press_counter_7seg

---
 rtl/press_counter_7seg_if.sv | 30 +++
 rtl/press_counter_7seg.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/press_counter_7seg_if.sv
// Bus bundle for press_counter_7seg: increment/clear requests in, count and
// multiplexed 7-segment drive out.
interface press_counter_7seg_if #(
  parameter int DIGITS = 4
);
  logic                  inc_pulse;
  logic                  clr;
  logic [4*DIGITS-1:0]   count_bcd;
  logic                  wrap;
  logic [DIGITS-1:0]     an;
  logic [6:0]            seg;

  modport master (
    output inc_pulse,
    output clr,
    input  count_bcd,
    input  wrap,
    input  an,
    input  seg
  );

  modport slave (
    input  inc_pulse,
    input  clr,
    output count_bcd,
    output wrap,
    output an,
    output seg
  );
endinterface

// File: rtl/press_counter_7seg.sv
// Button-press BCD counter with a time-multiplexed, active-low 7-segment
// display driver and optional leading-zero blanking.
module press_counter_7seg #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50_000,
  parameter int BLANK_LZ = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  press_counter_7seg_if.slave bus
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(SCAN_DIV - 1);

  logic [4*DIGITS-1:0] r_count;
  logic                r_wrap;
  logic [DIV_W-1:0]    r_div;
  logic [IDX_W-1:0]    r_idx;
  logic [DIGITS-1:0]   r_an;
  logic [6:0]          r_seg;

  logic [4*DIGITS-1:0] w_count_inc;
  logic                w_carry;
  logic [3:0]          w_digit;
  logic                w_blank;
  logic                w_upper_zero;
  logic [DIGITS-1:0]   w_an;

  // Active-low gfedcba pattern for one BCD digit.
  function automatic logic [6:0] f_seg_decode(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'd0:    pattern = 7'b1000000;
      4'd1:    pattern = 7'b1111001;
      4'd2:    pattern = 7'b0100100;
      4'd3:    pattern = 7'b0110000;
      4'd4:    pattern = 7'b0011001;
      4'd5:    pattern = 7'b0010010;
      4'd6:    pattern = 7'b0000010;
      4'd7:    pattern = 7'b1111000;
      4'd8:    pattern = 7'b0000000;
      4'd9:    pattern = 7'b0010000;
      default: pattern = 7'b1111111;
    endcase
    return pattern;
  endfunction

  // Ripple BCD increment; a carry surviving the top digit means all-9s rollover.
  always_comb begin
    w_count_inc = r_count;
    w_carry     = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_carry) begin
        if (r_count[4*i +: 4] == 4'd9) begin
          w_count_inc[4*i +: 4] = 4'd0;
        end else begin
          w_count_inc[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
          w_carry               = 1'b0;
        end
      end else begin
        w_count_inc[4*i +: 4] = r_count[4*i +: 4];
      end
    end
  end

  // Count register; clear beats increment and never raises wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= {(4*DIGITS){1'b0}};
      r_wrap  <= 1'b0;
    end else if (bus.clr) begin
      r_count <= {(4*DIGITS){1'b0}};
      r_wrap  <= 1'b0;
    end else if (bus.inc_pulse) begin
      r_count <= w_count_inc;
      r_wrap  <= w_carry;
    end else begin
      r_count <= r_count;
      r_wrap  <= 1'b0;
    end
  end

  // Scan divider and digit index, free-running and independent of counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= {DIV_W{1'b0}};
      r_idx <= {IDX_W{1'b0}};
    end else if (r_div == LAST_DIV) begin
      r_div <= {DIV_W{1'b0}};
      if (r_idx == LAST_IDX) begin
        r_idx <= {IDX_W{1'b0}};
      end else begin
        r_idx <= r_idx + {{(IDX_W-1){1'b0}}, 1'b1};
      end
    end else begin
      r_div <= r_div + {{(DIV_W-1){1'b0}}, 1'b1};
      r_idx <= r_idx;
    end
  end

  // Select the scanned digit; walking from the top tracks whether it and
  // every higher digit are zero, which is the blanking condition.
  always_comb begin
    w_digit      = 4'd0;
    w_blank      = 1'b0;
    w_upper_zero = 1'b1;
    w_an         = {DIGITS{1'b1}};
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_upper_zero = w_upper_zero && (r_count[4*i +: 4] == 4'd0);
      if (IDX_W'(i) == r_idx) begin
        w_digit = r_count[4*i +: 4];
        w_blank = (BLANK_LZ != 0) && (i != 0) && w_upper_zero;
        w_an[i] = 1'b0;
      end else begin
        w_an[i] = 1'b1;
      end
    end
  end

  // Registered display pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an  <= {DIGITS{1'b1}};
      r_seg <= 7'b1111111;
    end else begin
      r_an  <= w_an;
      if (w_blank) begin
        r_seg <= 7'b1111111;
      end else begin
        r_seg <= f_seg_decode(w_digit);
      end
    end
  end

  assign bus.count_bcd = r_count;
  assign bus.wrap      = r_wrap;
  assign bus.an        = r_an;
  assign bus.seg       = r_seg;

endmodule
